// File: rtl/apb_s3_master.sv
// apb_s3_master: APB master stage driving the slave-3 port of the NoC bridge.
//
// Takes single-beat read/write requests over a valid/ready handshake, runs each
// one as an APB SETUP->ACCESS transfer on the S3_* pins and returns read data
// plus error status on a buffered valid/ready response channel. A PREADY
// timeout forces an error completion so a hung slave cannot stall the fabric.
//
// Ports:
//   ACLK, ARESETn                 clock (rising edge), async active-low reset
//   req_valid/req_ready           request handshake
//   req_write/addr/wdata/strb     request payload
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_err             response payload (rdata is 0 for writes/timeouts)
//   S3_PSEL..S3_PSTRB             registered APB master outputs
//   S3_PRDATA/PREADY/PSLVERR      APB slave returns
//
// Parameters:
//   TIMEOUT_CYCLES  ACCESS cycles allowed before a forced error; 0 disables
//   CNT_W           timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
module apb_s3_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        S3_PSEL,
  output logic        S3_PENABLE,
  output logic        S3_PWRITE,
  output logic [31:0] S3_PADDR,
  output logic [31:0] S3_PDATA,
  output logic [3:0]  S3_PSTRB,
  input  logic [31:0] S3_PRDATA,
  input  logic        S3_PREADY,
  input  logic        S3_PSLVERR
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  localparam bit              TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CntLast  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               psel_q, penable_q, pwrite_q;
  logic [31:0]        paddr_q, pdata_q;
  logic [3:0]         pstrb_q;
  logic               rsp_valid_q, rsp_err_q;
  logic [31:0]        rsp_rdata_q;
  logic               timeout_hit;

  assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pdata_q     <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Request lands straight in the APB output registers; that is SETUP.
          if (req_valid) begin
            psel_q   <= 1'b1;
            pwrite_q <= req_write;
            paddr_q  <= req_addr;
            pdata_q  <= req_write ? req_wdata : '0;
            pstrb_q  <= req_write ? req_strb : '0;
            state_q  <= StSetup;
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= StAccess;
        end
        StAccess: begin
          // PREADY is tested first so it wins over a same-cycle timeout.
          if (S3_PREADY) begin
            rsp_rdata_q <= pwrite_q ? '0 : S3_PRDATA;
            rsp_err_q   <= S3_PSLVERR;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else if (timeout_hit) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gated by ARESETn so req_ready reads 0 while reset is held, 1 right after.
  assign req_ready  = ARESETn && (state_q == StIdle);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign S3_PSEL    = psel_q;
  assign S3_PENABLE = penable_q;
  assign S3_PWRITE  = pwrite_q;
  assign S3_PADDR   = paddr_q;
  assign S3_PDATA   = pdata_q;
  assign S3_PSTRB   = pstrb_q;

endmodule
